// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the M-extension divide controller.
//                Holds the operand width, the counter width, the controller
//                state encoding, the op encoding and a two's-complement helper.
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_PREP = 3'd1;
    localparam state_t ST_DIV  = 3'd2;
    localparam state_t ST_FIX  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // Op encoding as presented by the decoder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return (~x) + XLEN'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clz_div_ctrl_clz.sv
`default_nettype none
// ============================================================================
//  Module      : clz_div_ctrl_clz
//  Description : Combinational count-leading-zeros unit.
//                i_value : operand to scan
//                o_count : number of leading zeros, 0..XLEN (XLEN only for 0)
//  Revision    : 1.0  initial release
// ============================================================================
module clz_div_ctrl_clz #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic [XLEN-1:0]  i_value,
    output logic [CNT_W-1:0] o_count
);

    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        o_count = CNT_W'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (i_value[i]) begin
                o_count = CNT_W'(XLEN - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clz_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clz_div_ctrl
//  Description : Multi-cycle DIV/DIVU/REM/REMU controller. Radix-2 restoring
//                divide; the dividend's leading zeros are skipped using the
//                CLZ unit, so a normal op takes 32 - clz(|dividend|) iterations.
//  Ports       : clk, rst       clock, synchronous active-high reset
//                in_valid/ready request handshake (op, rs1, rs2)
//                flush          kills the in-flight op, no result produced
//                out_valid/ready result handshake (result)
//                busy           high whenever the controller is not idle
//  Revision    : 1.0  initial release
// ============================================================================
module clz_div_ctrl #(
    parameter int XLEN  = div_pkg::XLEN,
    parameter int CNT_W = div_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    import div_pkg::*;

    localparam logic [CNT_W-1:0] c_xlen    = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_a;        // latched rs1
    logic [XLEN-1:0]   r_b;        // latched rs2
    logic [XLEN-1:0]   r_d;        // dividend shift register
    logic [XLEN-1:0]   r_r;        // partial remainder
    logic [XLEN-1:0]   r_q;        // quotient shift register
    logic [XLEN-1:0]   r_div;      // |divisor|
    logic [XLEN-1:0]   r_result;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_signed;
    logic              w_is_rem;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [CNT_W-1:0]  w_clz;
    logic [CNT_W-1:0]  w_k;
    logic [XLEN:0]     w_r_sh;
    logic [XLEN:0]     w_diff;
    logic              w_fits;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;

    assign w_signed = (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_is_rem = (r_op == OP_REM) || (r_op == OP_REMU);
    assign w_a_neg  = w_signed & r_a[XLEN-1];
    assign w_b_neg  = w_signed & r_b[XLEN-1];
    assign w_abs_a  = w_a_neg ? negate(r_a) : r_a;
    assign w_abs_b  = w_b_neg ? negate(r_b) : r_b;

    clz_div_ctrl_clz #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_clz (
        .i_value (w_abs_a),
        .o_count (w_clz)
    );

    assign w_k = c_xlen - w_clz;

    // The shifted remainder can exceed 32 bits when the divisor is above
    // 2^31, so the trial subtract is 33 bits wide; bit XLEN is the borrow.
    assign w_r_sh = {r_r, r_d[XLEN-1]};
    assign w_diff = w_r_sh - {1'b0, r_div};
    assign w_fits = ~w_diff[XLEN];

    assign w_q_fix = (w_a_neg ^ w_b_neg) ? negate(r_q) : r_q;
    assign w_r_fix = w_a_neg ? negate(r_r) : r_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= 2'b00;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_r      <= '0;
            r_q      <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op    <= op;
                        r_a     <= rs1;
                        r_b     <= rs2;
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_d   <= w_abs_a << w_clz;
                    r_r   <= '0;
                    r_q   <= '0;
                    r_div <= w_abs_b;
                    r_cnt <= w_k;
                    if (r_b == '0) begin
                        r_result <= w_is_rem ? r_a : '1;
                        r_state  <= ST_DONE;
                    end else if (w_signed && (r_a == c_int_min) && (r_b == '1)) begin
                        r_result <= w_is_rem ? '0 : c_int_min;
                        r_state  <= ST_DONE;
                    end else if (r_a == '0) begin
                        r_result <= '0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    r_d   <= r_d << 1;
                    r_r   <= w_fits ? w_diff[XLEN-1:0] : w_r_sh[XLEN-1:0];
                    r_q   <= {r_q[XLEN-2:0], w_fits};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_is_rem ? w_r_fix : w_q_fix;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_clz_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clz_div_ctrl
//  Description : Self-checking bench for clz_div_ctrl: a table of directed
//                divide/remainder vectors with expected result and latency,
//                followed by backpressure, flush and mid-op reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clz_div_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_cmp;
    int n_fail;

    clz_div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op and follow it to retirement. Latency is counted in
    // cycles after the accept cycle t.
    task automatic run_op(input int idx, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic saw_ready;
        @(negedge clk);
        op        = o;
        rs1       = a;
        rs2       = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        lat       = 1;
        saw_ready = 1'b0;
        while (!out_valid && lat < 60) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(exp_lat));
        check($sformatf("vec%0d_result", idx), result, exp);
        check($sformatf("vec%0d_in_ready_low_while_busy", idx), {31'd0, saw_ready}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("vec%0d_retire_out_valid", idx), {31'd0, out_valid}, 32'd0);
        check($sformatf("vec%0d_retire_in_ready", idx), {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int   lat;
        logic seen;

        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 2'b00;
        rs1       = '0;
        rs2       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        //            op     dividend       divisor        expected       lat
        vecs[0]  = '{2'b01, 32'd100,       32'd7,         32'd14,        10};
        vecs[1]  = '{2'b11, 32'd100,       32'd7,         32'd2,         10};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 6};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 6};
        vecs[4]  = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 6};
        vecs[5]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         6};
        vecs[6]  = '{2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
        vecs[7]  = '{2'b10, 32'd5,         32'd0,         32'd5,         2};
        vecs[8]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
        vecs[9]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2};
        vecs[10] = '{2'b01, 32'd0,         32'd9,         32'd0,         2};
        vecs[11] = '{2'b01, 32'h8000_0000, 32'd1,         32'h8000_0000, 35};
        vecs[12] = '{2'b00, 32'h8000_0000, 32'd2,         32'hC000_0000, 35};
        vecs[13] = '{2'b11, 32'hFFFF_FFFF, 32'd10,        32'd5,         35};
        vecs[14] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         35};
        vecs[15] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         35};

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        op = 2'b01; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd10);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_hold%0d_result", c), result, 32'd14);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_retire_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_retire_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush on the third DIV cycle.
        @(negedge clk);
        op = 2'b01; rs1 = 32'h8000_0000; rs2 = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;            // PREP
        in_valid = 1'b0;
        @(posedge clk); #1;            // DIV cycle 1
        @(posedge clk); #1;            // DIV cycle 2
        @(posedge clk); #1;            // DIV cycle 3
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_after", {31'd0, busy}, 32'd0);
        check("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("flush_no_out_valid", {31'd0, seen}, 32'd0);

        // Flush coincident with an accept drops the request.
        @(negedge clk);
        op = 2'b01; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_accept_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("flush_accept_no_activity", {31'd0, seen}, 32'd0);

        // Reset in the middle of a divide; result is nonzero beforehand.
        check("pre_rst_result", result, 32'd14);
        @(negedge clk);
        op = 2'b01; rs1 = 32'h8000_0000; rs2 = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_result", result, 32'd0);

        // Controller is usable again afterwards.
        run_op(99, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
